// File: rtl/request_encoder_if.sv
// request_encoder_if: request lines, enable, and the valid/ready index
// handshake of the 4-to-2 request encoder. The encoder uses the slave
// modport; the requester/consumer side uses the master modport.
interface request_encoder_if;
    logic in0;
    logic in1;
    logic in2;
    logic in3;
    logic enable;
    logic ready;
    logic addr0;
    logic addr1;
    logic valid;

    modport master (
        output in0, in1, in2, in3, enable, ready,
        input  addr0, addr1, valid
    );

    modport slave (
        input  in0, in1, in2, in3, enable, ready,
        output addr0, addr1, valid
    );
endinterface

// File: rtl/request_encoder.sv
// request_encoder: registered 4-to-2 request encoder with a valid/ready
// output handshake. Request lines accumulate into a pending set; one index
// is selected and held on addr1:addr0 until the consumer accepts it.
//
// Build option: define REQUEST_ENCODER_ROUND_ROBIN_EN for round-robin
// selection (the scan starts just after the last accepted index). Without
// it the scan pointer stays at 0: fixed priority, in0 highest, in3 lowest.
module request_encoder (
    input  logic                clk,
    input  logic                reset,
    request_encoder_if.slave    bus
);

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

    state_t      state_r;
    state_t      state_next_s;
    logic [3:0]  pending_r;
    logic [3:0]  req_s;
    logic [3:0]  clr_s;
    logic [3:0]  pend_next_s;
    logic [1:0]  ptr_r;
    logic [1:0]  ptr_next_s;
    logic [1:0]  addr_r;
    logic [1:0]  addr_next_s;
    logic        valid_r;
    logic        valid_next_s;
    logic        hs_s;
    logic        sel_open_s;

    // One-hot mask of a 2-bit index.
    function automatic logic [3:0] onehot(input logic [1:0] idx);
        logic [3:0] mask;
        case (idx)
            2'd0:    mask = 4'b0001;
            2'd1:    mask = 4'b0010;
            2'd2:    mask = 4'b0100;
            2'd3:    mask = 4'b1000;
            default: mask = 4'b0000;
        endcase
        return mask;
    endfunction

    // First set bit of p scanning s, s+1, s+2, s+3 (mod 4). Scanning from
    // the far end backwards lets the nearest hit overwrite the others.
    function automatic logic [1:0] select(input logic [3:0] p, input logic [1:0] s);
        logic [1:0] idx;
        logic [1:0] sel;
        sel = s;
        for (int k = 3; k >= 0; k--) begin
            idx = s + 2'(k);
            if (p[idx]) begin
                sel = idx;
            end else begin
                sel = sel;
            end
        end
        return sel;
    endfunction

    // Gate incoming requests, detect the handshake and build the next pending set.
    always_comb begin
        req_s       = bus.enable ? {bus.in3, bus.in2, bus.in1, bus.in0} : 4'b0000;
        hs_s        = valid_r & bus.ready;
        clr_s       = hs_s ? onehot(addr_r) : 4'b0000;
        pend_next_s = (pending_r & ~clr_s) | req_s;
    end

    // Scan pointer: advances past the accepted index, or stays at 0 for fixed priority.
    always_comb begin
`ifdef REQUEST_ENCODER_ROUND_ROBIN_EN
        if (hs_s) begin
            ptr_next_s = addr_r + 2'd1;
        end else begin
            ptr_next_s = ptr_r;
        end
`else
        ptr_next_s = ptr_r;
`endif
    end

    // FSM next state: select only when idle or on accept; otherwise hold the presented index.
    always_comb begin
        state_next_s = state_r;
        addr_next_s  = addr_r;
        valid_next_s = valid_r;
        sel_open_s   = 1'b0;
        case (state_r)
            IDLE:    sel_open_s = 1'b1;
            PRESENT: sel_open_s = hs_s;
            default: sel_open_s = 1'b1;
        endcase
        if (sel_open_s) begin
            if (pend_next_s != 4'b0000) begin
                state_next_s = PRESENT;
                addr_next_s  = select(pend_next_s, ptr_next_s);
                valid_next_s = 1'b1;
            end else begin
                state_next_s = IDLE;
                addr_next_s  = addr_r;
                valid_next_s = 1'b0;
            end
        end else begin
            state_next_s = state_r;
            addr_next_s  = addr_r;
            valid_next_s = valid_r;
        end
    end

    // State registers; a synchronous reset drops any presented index unaccepted.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= IDLE;
            pending_r <= 4'b0000;
            ptr_r     <= 2'd0;
            addr_r    <= 2'd0;
            valid_r   <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            pending_r <= pend_next_s;
            ptr_r     <= ptr_next_s;
            addr_r    <= addr_next_s;
            valid_r   <= valid_next_s;
        end
    end

    assign bus.addr0 = addr_r[0];
    assign bus.addr1 = addr_r[1];
    assign bus.valid = valid_r;

endmodule

// File: tb/tb_request_encoder.sv
// tb_request_encoder: table-driven vectors and hand sequences for the
// request_encoder corner cases, followed by randomized traffic checked
// against a behavioural model of pending requests and index selection.
module tb_request_encoder;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    request_encoder_if bus ();

    request_encoder dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       en;
        logic [3:0] in;
        logic       rdy;
        logic       exp_v;
        logic [1:0] exp_a;
    } vec_t;

    vec_t vecs [25];

    // Behavioural model: which requests are outstanding, where the scan
    // starts, and which index (if any) is currently offered.
    bit m_pend [4];
    int m_ptr;
    int m_addr;
    bit m_valid;

    task automatic model_step(input logic r, input logic e, input logic [3:0] in, input logic rd);
        bit np [4];
        bit hs;
        bit found;
        int idx;
        if (r) begin
            for (int i = 0; i < 4; i++) m_pend[i] = 1'b0;
            m_ptr   = 0;
            m_addr  = 0;
            m_valid = 1'b0;
        end else begin
            hs = m_valid && rd;
            for (int i = 0; i < 4; i++)
                np[i] = (m_pend[i] && !(hs && m_addr == i)) || (e && in[i]);
`ifdef REQUEST_ENCODER_ROUND_ROBIN_EN
            if (hs) m_ptr = (m_addr + 1) % 4;
`else
            m_ptr = 0;
`endif
            if (!m_valid || hs) begin
                found = 1'b0;
                for (int k = 0; k < 4; k++) begin
                    idx = (m_ptr + k) % 4;
                    if (!found && np[idx]) begin
                        m_addr = idx;
                        found  = 1'b1;
                    end
                end
                m_valid = found;
            end
            for (int i = 0; i < 4; i++) m_pend[i] = np[i];
        end
    endtask

    // Drive one cycle of inputs, clock it, and compare the outputs either
    // against a fixed expectation or against the model.
    task automatic apply(input logic r, input logic e, input logic [3:0] in, input logic rd,
                         input bit use_const, input logic ev, input logic [1:0] ea,
                         input string name);
        logic [2:0] exp;
        logic [2:0] got;
        reset      = r;
        bus.enable = e;
        bus.in0    = in[0];
        bus.in1    = in[1];
        bus.in2    = in[2];
        bus.in3    = in[3];
        bus.ready  = rd;
        model_step(r, e, in, rd);
        @(posedge clk);
        #1;
        if (use_const) exp = {ev, ea};
        else           exp = {m_valid, 2'(m_addr)};
        got = {bus.valid, bus.addr1, bus.addr0};
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got valid=%0b addr=%0d, expected valid=%0b addr=%0d",
                     name, got[2], got[1:0], exp[2], exp[1:0]);
        end
    endtask

    int burst1 [4];
    int burst2 [4];

    initial begin
        checks   = 0;
        failures = 0;
        reset      = 1'b1;
        bus.enable = 1'b0;
        bus.in0    = 1'b0;
        bus.in1    = 1'b0;
        bus.in2    = 1'b0;
        bus.in3    = 1'b0;
        bus.ready  = 1'b0;
        model_step(1'b1, 1'b0, 4'b0000, 1'b0);

        //                 rst   en    in       rdy   v     addr
        vecs[0]  = '{1'b1, 1'b1, 4'b0000, 1'b0, 1'b0, 2'd0};
        vecs[1]  = '{1'b1, 1'b1, 4'b0000, 1'b0, 1'b0, 2'd0};
        vecs[2]  = '{1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 2'd0};
        vecs[3]  = '{1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 2'd0};
        vecs[4]  = '{1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 2'd0};
        vecs[5]  = '{1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 2'd0};
        vecs[6]  = '{1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 2'd0};
        vecs[7]  = '{1'b0, 1'b1, 4'b0100, 1'b0, 1'b1, 2'd2};
        vecs[8]  = '{1'b0, 1'b1, 4'b0000, 1'b0, 1'b1, 2'd2};
        vecs[9]  = '{1'b0, 1'b1, 4'b0000, 1'b0, 1'b1, 2'd2};
        vecs[10] = '{1'b0, 1'b1, 4'b0000, 1'b0, 1'b1, 2'd2};
        vecs[11] = '{1'b0, 1'b1, 4'b0000, 1'b1, 1'b0, 2'd2};
        vecs[12] = '{1'b0, 1'b1, 4'b0001, 1'b0, 1'b1, 2'd0};
        vecs[13] = '{1'b0, 1'b1, 4'b0000, 1'b1, 1'b0, 2'd0};
        vecs[14] = '{1'b0, 1'b1, 4'b0010, 1'b0, 1'b1, 2'd1};
        vecs[15] = '{1'b0, 1'b1, 4'b0000, 1'b1, 1'b0, 2'd1};
        vecs[16] = '{1'b0, 1'b1, 4'b1000, 1'b0, 1'b1, 2'd3};
        vecs[17] = '{1'b0, 1'b1, 4'b0000, 1'b1, 1'b0, 2'd3};
        vecs[18] = '{1'b0, 1'b0, 4'b0010, 1'b0, 1'b0, 2'd3};
        vecs[19] = '{1'b0, 1'b0, 4'b0010, 1'b0, 1'b0, 2'd3};
        vecs[20] = '{1'b0, 1'b0, 4'b0010, 1'b0, 1'b0, 2'd3};
        vecs[21] = '{1'b0, 1'b1, 4'b0010, 1'b0, 1'b1, 2'd1};
        vecs[22] = '{1'b0, 1'b1, 4'b0010, 1'b1, 1'b1, 2'd1};
        vecs[23] = '{1'b0, 1'b1, 4'b0000, 1'b1, 1'b0, 2'd1};
        vecs[24] = '{1'b0, 1'b1, 4'b0000, 1'b1, 1'b0, 2'd1};

        for (int i = 0; i < 25; i++) begin
            apply(vecs[i].rst, vecs[i].en, vecs[i].in, vecs[i].rdy,
                  1'b1, vecs[i].exp_v, vecs[i].exp_a, $sformatf("vec%0d", i));
        end

        // Burst of all four with ready held high. Last accept was index 1,
        // so round robin resumes at 2; fixed priority always starts at 0.
`ifdef REQUEST_ENCODER_ROUND_ROBIN_EN
        burst1 = '{2, 3, 0, 1};
`else
        burst1 = '{0, 1, 2, 3};
`endif
        burst2 = '{0, 1, 2, 3};

        apply(1'b0, 1'b1, 4'b1111, 1'b1, 1'b1, 1'b1, 2'(burst1[0]), "burst1_0");
        for (int j = 1; j < 4; j++)
            apply(1'b0, 1'b1, 4'b0000, 1'b1, 1'b1, 1'b1, 2'(burst1[j]), $sformatf("burst1_%0d", j));
        apply(1'b0, 1'b1, 4'b0000, 1'b1, 1'b1, 1'b0, 2'(burst1[3]), "burst1_end");

        // Grant index 3 so the round-robin scan wraps back to 0.
        apply(1'b0, 1'b1, 4'b1000, 1'b0, 1'b1, 1'b1, 2'd3, "grant3");
        apply(1'b0, 1'b1, 4'b0000, 1'b1, 1'b1, 1'b0, 2'd3, "grant3_acc");

        apply(1'b0, 1'b1, 4'b1111, 1'b1, 1'b1, 1'b1, 2'(burst2[0]), "burst2_0");
        for (int j = 1; j < 4; j++)
            apply(1'b0, 1'b1, 4'b0000, 1'b1, 1'b1, 1'b1, 2'(burst2[j]), $sformatf("burst2_%0d", j));
        apply(1'b0, 1'b1, 4'b0000, 1'b1, 1'b1, 1'b0, 2'd3, "burst2_end");

`ifndef REQUEST_ENCODER_ROUND_ROBIN_EN
        // Fixed priority: in0 held high starves the others until it drops.
        apply(1'b0, 1'b1, 4'b1111, 1'b1, 1'b1, 1'b1, 2'd0, "hold0_start");
        for (int j = 0; j < 6; j++)
            apply(1'b0, 1'b1, 4'b0001, 1'b1, 1'b1, 1'b1, 2'd0, $sformatf("hold0_%0d", j));
        apply(1'b0, 1'b1, 4'b0000, 1'b1, 1'b1, 1'b1, 2'd1, "hold0_rel1");
        apply(1'b0, 1'b1, 4'b0000, 1'b1, 1'b1, 1'b1, 2'd2, "hold0_rel2");
        apply(1'b0, 1'b1, 4'b0000, 1'b1, 1'b1, 1'b1, 2'd3, "hold0_rel3");
        apply(1'b0, 1'b1, 4'b0000, 1'b1, 1'b1, 1'b0, 2'd3, "hold0_end");
`endif

        // Reset in the same cycle as an accept drops everything pending.
        apply(1'b0, 1'b1, 4'b0111, 1'b0, 1'b1, 1'b1, 2'd0, "midrst_load");
        apply(1'b1, 1'b1, 4'b0000, 1'b1, 1'b1, 1'b0, 2'd0, "midrst_hit");
        for (int j = 0; j < 3; j++)
            apply(1'b0, 1'b1, 4'b0000, 1'b0, 1'b1, 1'b0, 2'd0, $sformatf("midrst_after%0d", j));

        // Randomized traffic against the model.
        for (int n = 0; n < 1500; n++) begin
            logic       r;
            logic       e;
            logic [3:0] in;
            logic       rd;
            r  = ($urandom_range(0, 80) == 0);
            e  = ($urandom_range(0, 3) != 0);
            in = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
            rd = ($urandom_range(0, 2) != 0);
            apply(r, e, in, rd, 1'b0, 1'b0, 2'd0, $sformatf("rand%0d", n));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
